// File: rtl/vad_hangover.sv
// vad_hangover: frame-level speech/non-speech smoother.
// The onset counter rejects short bursts of speech frames and the hangover
// counter bridges short pauses. The block also reports segment start/end
// pulses and a saturating segment-length count.
module vad_hangover #(
    parameter int ONSET_FRAMES    = 2,
    parameter int HANGOVER_FRAMES = 8,
    parameter int CNT_W           = 4,
    parameter int SEG_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             result_valid,
    input  logic [1:0]       result,
    output logic             vad_valid,
    output logic             vad_out,
    output logic             speech_start,
    output logic             speech_end,
    output logic [SEG_W-1:0] seg_len,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        ST_SIL    = 2'b00,
        ST_ONSET  = 2'b01,
        ST_SPEECH = 2'b10,
        ST_HANG   = 2'b11
    } state_t;

    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // Reject illegal parameter sets while the design is being elaborated.
    if (ONSET_FRAMES < 1 || ONSET_FRAMES > CNT_MAX) begin : g_bad_onset
        $error("vad_hangover: ONSET_FRAMES=%0d out of range 1..%0d", ONSET_FRAMES, CNT_MAX);
    end
    if (HANGOVER_FRAMES < 0 || HANGOVER_FRAMES > CNT_MAX) begin : g_bad_hang
        $error("vad_hangover: HANGOVER_FRAMES=%0d out of range 0..%0d", HANGOVER_FRAMES, CNT_MAX);
    end

    // Onset target and hangover reload, both held at the full counter width.
    localparam logic [CNT_W-1:0] ONSET_TGT = CNT_W'(ONSET_FRAMES);
    localparam logic [CNT_W-1:0] HANG_INIT =
        (HANGOVER_FRAMES > 0) ? CNT_W'(HANGOVER_FRAMES - 1) : '0;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] onset_cnt_q, onset_cnt_d;
    logic [CNT_W-1:0] hang_cnt_q, hang_cnt_d;
    logic             vad_valid_q, vad_valid_d;
    logic             vad_out_q, vad_out_d;
    logic             speech_start_q, speech_start_d;
    logic             speech_end_q, speech_end_d;
    logic [SEG_W-1:0] seg_len_q, seg_len_d;

    logic             is_speech;
    logic             is_noise;
    logic [SEG_W-1:0] seg_len_inc;
    logic [CNT_W-1:0] onset_cnt_inc;

    assign is_speech     = (result == 2'b10);
    assign is_noise      = (result == 2'b01);
    // The segment length sticks at all-ones instead of wrapping.
    assign seg_len_inc   = (seg_len_q == {SEG_W{1'b1}}) ? seg_len_q : seg_len_q + SEG_W'(1);
    assign onset_cnt_inc = onset_cnt_q + CNT_W'(1);

    // Next-state, counter and output computation for one accepted frame.
    always_comb begin
        state_d        = state_q;
        onset_cnt_d    = onset_cnt_q;
        hang_cnt_d     = hang_cnt_q;
        vad_valid_d    = 1'b0;
        vad_out_d      = vad_out_q;
        speech_start_d = 1'b0;
        speech_end_d   = 1'b0;
        seg_len_d      = seg_len_q;

        if (clear) begin
            // Clear beats a coincident frame: the frame is dropped silently.
            state_d     = ST_SIL;
            onset_cnt_d = '0;
            hang_cnt_d  = '0;
            vad_out_d   = 1'b0;
            seg_len_d   = '0;
        end else if (result_valid) begin
            vad_valid_d = 1'b1;
            if (!is_speech && !is_noise) begin
                // No decision: repeat the previous flag, keep counting speech.
                if (vad_out_q) begin
                    seg_len_d = seg_len_inc;
                end
            end else begin
                unique case (state_q)
                    ST_SIL: begin
                        vad_out_d = 1'b0;
                        if (is_speech) begin
                            if (ONSET_FRAMES == 1) begin
                                state_d        = ST_SPEECH;
                                vad_out_d      = 1'b1;
                                speech_start_d = 1'b1;
                                seg_len_d      = SEG_W'(1);
                            end else begin
                                state_d     = ST_ONSET;
                                onset_cnt_d = CNT_W'(1);
                            end
                        end
                    end
                    ST_ONSET: begin
                        vad_out_d = 1'b0;
                        if (is_speech) begin
                            onset_cnt_d = onset_cnt_inc;
                            if (onset_cnt_inc == ONSET_TGT) begin
                                state_d        = ST_SPEECH;
                                onset_cnt_d    = '0;
                                vad_out_d      = 1'b1;
                                speech_start_d = 1'b1;
                                seg_len_d      = SEG_W'(1);
                            end
                        end else begin
                            state_d     = ST_SIL;
                            onset_cnt_d = '0;
                        end
                    end
                    ST_SPEECH: begin
                        if (is_speech) begin
                            vad_out_d = 1'b1;
                            seg_len_d = seg_len_inc;
                        end else if (HANGOVER_FRAMES == 0) begin
                            state_d      = ST_SIL;
                            vad_out_d    = 1'b0;
                            speech_end_d = 1'b1;
                        end else begin
                            state_d    = ST_HANG;
                            hang_cnt_d = HANG_INIT;
                            vad_out_d  = 1'b1;
                            seg_len_d  = seg_len_inc;
                        end
                    end
                    ST_HANG: begin
                        if (is_speech) begin
                            state_d    = ST_SPEECH;
                            hang_cnt_d = '0;
                            vad_out_d  = 1'b1;
                            seg_len_d  = seg_len_inc;
                        end else if (hang_cnt_q == '0) begin
                            state_d      = ST_SIL;
                            vad_out_d    = 1'b0;
                            speech_end_d = 1'b1;
                        end else begin
                            hang_cnt_d = hang_cnt_q - CNT_W'(1);
                            vad_out_d  = 1'b1;
                            seg_len_d  = seg_len_inc;
                        end
                    end
                    default: begin
                        state_d = ST_SIL;
                    end
                endcase
            end
        end
    end

    // State and output registers; reset lands in SIL with no end pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_SIL;
            onset_cnt_q    <= '0;
            hang_cnt_q     <= '0;
            vad_valid_q    <= 1'b0;
            vad_out_q      <= 1'b0;
            speech_start_q <= 1'b0;
            speech_end_q   <= 1'b0;
            seg_len_q      <= '0;
        end else begin
            state_q        <= state_d;
            onset_cnt_q    <= onset_cnt_d;
            hang_cnt_q     <= hang_cnt_d;
            vad_valid_q    <= vad_valid_d;
            vad_out_q      <= vad_out_d;
            speech_start_q <= speech_start_d;
            speech_end_q   <= speech_end_d;
            seg_len_q      <= seg_len_d;
        end
    end

    assign vad_valid    = vad_valid_q;
    assign vad_out      = vad_out_q;
    assign speech_start = speech_start_q;
    assign speech_end   = speech_end_q;
    assign seg_len      = seg_len_q;
    assign state_o      = state_q;

endmodule

// File: doc/vad_hangover.md
# vad_hangover

Frame-level decision smoother that sits directly downstream of the two-class score comparator at the end of the BNN VAD pipeline. Consumes one raw per-frame class code per `result_valid` strobe and produces a debounced speech/non-speech flag using an onset counter (rejects isolated speech frames) and a hangover counter (bridges short pauses). Also emits segment start/end pulses and a saturating segment-length count for the host interface.

## Interface
Parameters:
- `ONSET_FRAMES`, default 2: consecutive speech frames needed to enter speech; legal range 1..2^CNT_W-1.
- `HANGOVER_FRAMES`, default 8: noise frames still flagged as speech after the last speech frame; legal range 0..2^CNT_W-1.
- `CNT_W`, default 4: width of the onset and hangover counters.
- `SEG_W`, default 8: width of `seg_len`.

Ports:
- `clk`, input, 1: the single clock; all logic is on its rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `clear`, input, 1: synchronous soft clear.
- `result_valid`, input, 1: one-cycle strobe, one per frame; back-to-back cycles are legal.
- `result`, input, 2: class code from the comparator. `2'b10` is speech, `2'b01` is noise, and `2'b00`/`2'b11` mean no decision.
- `vad_valid`, output, 1: one-cycle pulse, one cycle after each accepted `result_valid`.
- `vad_out`, output, 1: smoothed decision for the frame; held between pulses.
- `speech_start`, output, 1: pulse coincident with the `vad_valid` of the frame that enters SPEECH.
- `speech_end`, output, 1: pulse coincident with the `vad_valid` of the frame that returns to SIL from SPEECH or HANG.
- `seg_len`, output, SEG_W: frame count of the current or most recent speech segment.
- `state_o`, output, 2: current state, encoded SIL=00, ONSET=01, SPEECH=10, HANG=11.

## Operation
- State register `state` plus counters `onset_cnt` and `hang_cnt` (CNT_W bits each). State changes only on accepted frames.
- A no-decision frame (00 or 11):
  - No state or counter change.
  - `vad_valid` still pulses.
  - `vad_out` repeats its previous value.
  - `seg_len` increments if `vad_out` is 1.
- SIL:
  - Speech frame: if ONSET_FRAMES==1, go to SPEECH, start the segment, output `vad_out`=1. Otherwise go to ONSET with `onset_cnt`=1 and output `vad_out`=0.
  - Noise frame: stay in SIL, `vad_out`=0.
- ONSET:
  - Speech frame: increment `onset_cnt`. If it reaches ONSET_FRAMES, go to SPEECH, start the segment, output `vad_out`=1. Otherwise output `vad_out`=0.
  - Noise frame: go to SIL, `onset_cnt`=0, `vad_out`=0.
- SPEECH:
  - Speech frame: stay in SPEECH, `vad_out`=1.
  - Noise frame: if HANGOVER_FRAMES==0, go to SIL with `speech_end` and `vad_out`=0. Otherwise go to HANG with `hang_cnt`=HANGOVER_FRAMES-1 and `vad_out`=1.
- HANG:
  - Speech frame: go to SPEECH, `vad_out`=1, no end pulse.
  - Noise frame with `hang_cnt`==0: go to SIL with `speech_end` and `vad_out`=0.
  - Noise frame with `hang_cnt`>0: decrement `hang_cnt`, `vad_out`=1.
- Starting a segment means `speech_start`=1 and `seg_len`=1.
- `seg_len` rules:
  - Increments by 1 on every later frame output with `vad_out`=1.
  - Saturates at all-ones.
  - Holds its value after `speech_end` until the next `speech_start`.
- `clear` behaviour:
  - Forces SIL and zeroes both counters, `seg_len`, `vad_out`, and all pulses.
  - Emits no `speech_end`.
  - If `clear` and `result_valid` are asserted in the same cycle, `clear` wins, the frame is dropped, and no `vad_valid` is issued.

## Timing
- All outputs are registered. Latency is 1 cycle from `result_valid` to `vad_valid`/`vad_out`/pulses/`seg_len`/`state_o`.
- Throughput is one frame per cycle.
- Reset values (asserted asynchronously on `rst`):
  - `state_o`=00, `vad_out`=0, `vad_valid`=0, `speech_start`=0, `speech_end`=0, `seg_len`=0.
  - Internal counters are 0.
- Reset in SPEECH or HANG emits no `speech_end`.
- The first frame after `rst` deasserts is processed from SIL.
- `speech_start` and `speech_end` are never high in the same cycle, and each is high only while `vad_valid` is high.
- Counter compares use the full CNT_W width.
- Parameter values outside their legal range are a configuration error and trigger a simulation `$error` at elaboration.

## Test plan
All scenarios use default parameters. "s" = speech frame, "n" = noise frame, "x" = `2'b00`.
- Isolated speech: reset, then s, n, n.
  - Required: `vad_out` 0,0,0; no `speech_start`; `state_o` 01 after s, then 00.
- Onset and segment length: s, s, s, s, s, then n×9.
  - Required: `vad_out` 0,1,1,1,1; `speech_start` with the second frame; then 1 for the first 8 n frames.
  - 9th n gives `vad_out`=0 with `speech_end`; `seg_len`=12 and holds.
- Hangover bridging: enter SPEECH, then n, n, n, s, then n×9.
  - Required: no `speech_end` until the 9th trailing n.
  - `state_o` goes 11 on the first n and 10 on the s.
- No-decision frames in onset: s, x, s.
  - Required: `vad_out` 0,0,1; `speech_start` on the third frame; `vad_valid` on all three.
- Clear collision: in HANG, assert `clear` together with `result_valid`(s).
  - Required: no `vad_valid`; `state_o`=00; `seg_len`=0; no pulses.
  - A following single s gives `vad_out`=0.
- Async reset mid-segment: pulse `rst` between clock edges during SPEECH.
  - Required: outputs reach reset values before the next edge; no `speech_end`; the next s enters ONSET.
